dmem_portb_arbiter: RTL and testbench

Round-robin arbiter that shares port B of the data-memory block RAM (the port used for debug access in the write-back segment) between two requesters: requester 0 (debug host) and requester 1 (program loader / DMA). It grants at most one access per cycle and drives the RAM's byte write-enable, address and write data. It tracks the RAM's one-cycle synchronous read latency so that read data is returned only to the requester that issued the read. It also supports locked bursts of bounded length.

---
 rtl/dmem_portb_arbiter.sv | 122 ++++++++++++
 tb/tb_dmem_portb_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_portb_arbiter.sv
// Round-robin arbiter for data-memory port B (debug host vs. loader/DMA) with bounded locked bursts.
// Build option: DMEM_ARB_FIXED_PRIO_EN gives requester 0 absolute priority and unbounded locking.
module dmem_portb_arbiter #(
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        lock0,
    input  logic        lock1,
    input  logic [3:0]  we0,
    input  logic [3:0]  we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wd0,
    input  logic [31:0] wd1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic [3:0]  ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_dout
);

    typedef struct packed {
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wd;
    } acc_t;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    localparam logic [CNT_W-1:0] CNT_SAT = '1;
`else
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_BURST);
`endif

    logic             last, owner, rd_pend, rd_tag;
    logic [CNT_W-1:0] burst_cnt, cnt_nxt;
    logic [1:0]       req, lock;
    acc_t             acc [2];
    acc_t             sel;
    logic             any_req, win, burst_act, lock_ok;

    assign req     = {req1, req0};
    assign lock    = {lock1, lock0};
    assign acc[0]  = '{we: we0, addr: addr0, wd: wd0};
    assign acc[1]  = '{we: we1, addr: addr1, wd: wd1};
    assign any_req = |req;

    // A burst stays live only while its owner keeps requesting.
    assign burst_act = (burst_cnt != '0) && req[owner];

    always_comb begin
        win = 1'b0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        win = ~req[0];
`else
        if (&req) begin
            if (burst_act)
                win = (burst_cnt == CNT_SAT) ? ~owner : owner;
            else
                win = ~last;
        end else begin
            win = req[1];
        end
`endif
    end

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign lock_ok = lock[win] && !win;
`else
    assign lock_ok = lock[win];
`endif

    always_comb begin
        cnt_nxt = '0;
        if (lock_ok) begin
            if (win == owner && burst_act)
                cnt_nxt = (burst_cnt == CNT_SAT) ? burst_cnt : burst_cnt + CNT_W'(1);
            else
                cnt_nxt = CNT_W'(1);
        end
    end

    assign sel      = acc[win];
    assign gnt0     = any_req && !win;
    assign gnt1     = any_req && win;
    assign ram_we   = any_req ? sel.we   : 4'b0;
    assign ram_addr = any_req ? sel.addr : 32'b0;
    assign ram_din  = any_req ? sel.wd   : 32'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last      <= 1'b1;
            owner     <= 1'b0;
            burst_cnt <= '0;
            rd_pend   <= 1'b0;
            rd_tag    <= 1'b0;
        end else if (any_req) begin
            last      <= win;
            owner     <= win;
            burst_cnt <= cnt_nxt;
            rd_pend   <= (sel.we == 4'b0);
            rd_tag    <= win;
        end else begin
            rd_pend   <= 1'b0;
        end
    end

    // Read data is steered by the registered tag, so it clears with reset immediately.
    assign rvalid0 = rd_pend && !rd_tag;
    assign rvalid1 = rd_pend && rd_tag;
    assign rdata0  = rvalid0 ? ram_dout : 32'b0;
    assign rdata1  = rvalid1 ? ram_dout : 32'b0;

endmodule

// File: tb/tb_dmem_portb_arbiter.sv
// Bench for dmem_portb_arbiter: directed vector table, corner sequences, and random traffic vs. a reference model.
module tb_dmem_portb_arbiter;
    localparam int MAXB = 3;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    localparam int SAT = 255;
`else
    localparam int SAT = MAXB;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = '0, lock = '0;
    logic [3:0]  we [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1, ram_addr, ram_din, ram_dout;
    logic [3:0]  ram_we;

    logic [31:0] ram [256];
    logic [31:0] refmem [256];

    int nchk = 0, nerr = 0;
    int m_last, m_owner, m_run, m_rw;
    bit m_rv;
    logic [31:0] m_rd;

    typedef struct {
        bit r0, r1, l0, l1;
        logic [3:0] we0, we1;
        logic [31:0] a0, a1, d0, d1;
        bit chkg, eg0, eg1;
    } vec_t;

    vec_t tv [$];

    dmem_portb_arbiter #(.MAX_BURST(MAXB), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req[0]), .req1(req[1]), .lock0(lock[0]), .lock1(lock[1]),
        .we0(we[0]), .we1(we[1]), .addr0(ad[0]), .addr1(ad[1]), .wd0(wd[0]), .wd1(wd[1]),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM behind port B.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (ram_we[b]) ram[ram_addr[9:2]][8*b +: 8] <= ram_din[8*b +: 8];
        ram_dout <= ram[ram_addr[9:2]];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(bit r0, bit r1, bit l0, bit l1, logic [3:0] we0, logic [3:0] we1,
                                logic [31:0] a0, logic [31:0] a1, logic [31:0] d0, bit chkg, bit eg0, bit eg1);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.l0 = l0; v.l1 = l1; v.we0 = we0; v.we1 = we1;
        v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = 32'h0;
        v.chkg = chkg; v.eg0 = eg0; v.eg1 = eg1;
        return v;
    endfunction

    task automatic model_reset();
        m_last = 1; m_owner = 0; m_run = 0; m_rv = 0; m_rw = 0; m_rd = '0;
    endtask

    // Winner from the arbitration rules; -1 means no grant.
    function automatic int model_winner();
        bit active;
        if (!req[0] && !req[1]) return -1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        return req[0] ? 0 : 1;
`else
        if (req[0] != req[1]) return req[0] ? 0 : 1;
        active = (m_run > 0) && req[m_owner];
        if (active) return (m_run == SAT) ? 1 - m_owner : m_owner;
        return 1 - m_last;
`endif
    endfunction

    task automatic model_check();
        int w;
        w = model_winner();
        chk("gnt0", gnt0, w == 0);
        chk("gnt1", gnt1, w == 1);
        chk("ram_we", ram_we, (w < 0) ? 4'h0 : we[w]);
        chk("ram_addr", ram_addr, (w < 0) ? 32'h0 : ad[w]);
        chk("ram_din", ram_din, (w < 0) ? 32'h0 : wd[w]);
        chk("rvalid0", rvalid0, m_rv && m_rw == 0);
        chk("rvalid1", rvalid1, m_rv && m_rw == 1);
        chk("rdata0", rdata0, (m_rv && m_rw == 0) ? m_rd : 32'h0);
        chk("rdata1", rdata1, (m_rv && m_rw == 1) ? m_rd : 32'h0);
    endtask

    // Advance the model across the coming rising edge.
    task automatic model_advance();
        int w;
        bit active, lk;
        w = model_winner();
        if (w < 0) begin
            m_rv = 0;
            return;
        end
        active = (m_run > 0) && req[m_owner];
`ifdef DMEM_ARB_FIXED_PRIO_EN
        lk = lock[w] && w == 0;
`else
        lk = lock[w];
`endif
        if (lk) m_run = (w == m_owner && active) ? ((m_run + 1 > SAT) ? SAT : m_run + 1) : 1;
        else    m_run = 0;
        m_last = w; m_owner = w;
        m_rv = (we[w] == 4'h0); m_rw = w;
        m_rd = refmem[ad[w][9:2]];
        for (int b = 0; b < 4; b++)
            if (we[w][b]) refmem[ad[w][9:2]][8*b +: 8] = wd[w][8*b +: 8];
    endtask

    task automatic drive(input vec_t v);
        req[0] = v.r0; req[1] = v.r1; lock[0] = v.l0; lock[1] = v.l1;
        we[0] = v.we0; we[1] = v.we1; ad[0] = v.a0; ad[1] = v.a1; wd[0] = v.d0; wd[1] = v.d1;
    endtask

    task automatic cyc(input vec_t v);
        @(posedge clk); #1;
        drive(v);
        @(negedge clk);
        model_check();
        if (v.chkg) begin
            chk("tbl_gnt0", gnt0, v.eg0);
            chk("tbl_gnt1", gnt1, v.eg1);
        end
        model_advance();
    endtask

    initial begin
        vec_t idle, v;
        idle = mk(0, 0, 0, 0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 1, 0, 0);
        for (int i = 0; i < 256; i++) begin
            ram[i] = 32'hA5000000 ^ (i * 32'h00010203);
            refmem[i] = ram[i];
        end
`ifdef DMEM_ARB_FIXED_PRIO_EN
        tv.push_back(mk(0, 1, 0, 1, 4'h0, 4'h0, 32'h10, 32'h20, 32'h0, 1, 0, 1));
        tv.push_back(mk(0, 1, 0, 1, 4'h0, 4'h0, 32'h10, 32'h24, 32'h0, 1, 0, 1));
        tv.push_back(mk(1, 1, 0, 1, 4'h0, 4'h0, 32'h10, 32'h28, 32'h0, 1, 1, 0));
        tv.push_back(mk(1, 1, 1, 1, 4'h0, 4'h0, 32'h14, 32'h28, 32'h0, 1, 1, 0));
        tv.push_back(mk(0, 1, 0, 1, 4'h0, 4'h0, 32'h14, 32'h28, 32'h0, 1, 0, 1));
        tv.push_back(idle);
`else
        for (int i = 0; i < 4; i++)
            tv.push_back(mk(1, 1, 0, 0, 4'h0, 4'h0, 32'h10, 32'h20, 32'h0, 1, i % 2 == 0, i % 2 == 1));
        tv.push_back(idle);
        tv.push_back(mk(1, 0, 0, 0, 4'hF, 4'h0, 32'h40, 32'h0, 32'hDEADBEEF, 1, 1, 0));
        tv.push_back(mk(0, 1, 0, 0, 4'h0, 4'h0, 32'h0, 32'h40, 32'h0, 1, 0, 1));
        tv.push_back(idle);
        tv.push_back(mk(0, 1, 0, 1, 4'h0, 4'h0, 32'h0, 32'h80, 32'h0, 1, 0, 1));
        tv.push_back(mk(1, 1, 0, 1, 4'h0, 4'h0, 32'h30, 32'h84, 32'h0, 1, 0, 1));
        tv.push_back(mk(1, 1, 0, 1, 4'h0, 4'h0, 32'h30, 32'h88, 32'h0, 1, 0, 1));
        tv.push_back(mk(1, 1, 0, 1, 4'h0, 4'h0, 32'h30, 32'h8C, 32'h0, 1, 1, 0));
        tv.push_back(mk(1, 1, 0, 1, 4'h0, 4'h0, 32'h34, 32'h8C, 32'h0, 1, 0, 1));
        tv.push_back(mk(1, 1, 0, 1, 4'h0, 4'h0, 32'h34, 32'h90, 32'h0, 1, 0, 1));
        tv.push_back(mk(1, 1, 0, 1, 4'h0, 4'h0, 32'h34, 32'h94, 32'h0, 1, 0, 1));
        tv.push_back(mk(1, 0, 0, 0, 4'h0, 4'h0, 32'h34, 32'h0, 32'h0, 1, 1, 0));
        tv.push_back(idle);
`endif
        drive(idle);
        model_reset();
        #3;
        model_check();
        @(negedge clk); rst_n = 1'b1;

        foreach (tv[i]) cyc(tv[i]);

        for (int i = 0; i < 5; i++) cyc(idle);
        chk("idle_ram_we", ram_we, 4'h0);

        // Reset lands while a read result is in flight.
        cyc(mk(1, 0, 0, 0, 4'h0, 4'h0, 32'h10, 32'h0, 32'h0, 1, 1, 0));
        @(posedge clk); #1;
        drive(idle);
        rst_n = 1'b0;
        #1;
        chk("rst_rvalid0", rvalid0, 1'b0);
        chk("rst_rdata0", rdata0, 32'h0);
        chk("rst_rvalid1", rvalid1, 1'b0);
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        cyc(mk(1, 1, 0, 0, 4'h0, 4'h0, 32'h18, 32'h1C, 32'h0, 1, 1, 0));

        for (int i = 0; i < 400; i++) begin
            v.r0 = ($urandom_range(0, 3) != 0); v.r1 = ($urandom_range(0, 3) != 0);
            v.l0 = ($urandom_range(0, 2) == 0); v.l1 = ($urandom_range(0, 1) == 0);
            v.we0 = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
            v.we1 = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
            v.a0 = $urandom & 32'h3FF; v.a1 = $urandom & 32'h3FF;
            v.d0 = $urandom; v.d1 = $urandom;
            v.chkg = 0; v.eg0 = 0; v.eg1 = 0;
            cyc(v);
        end
        cyc(idle);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
